// File: rtl/alu_op_sequencer.sv
// Multi-cycle control FSM sequencing register reads, ALU selects and write-back for 16-bit instructions.
// Optional build macro ALU_OP_SEQ_TRAP_EN: illegal instructions lock into TRAP (err=1) until reset.
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      instr,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [2:0]       rd_addr,
  output logic [2:0]       wr_addr,
  output logic             wr_en,
  output logic             vsel,
  output logic [WIDTH-1:0] sximm,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             addSubVals,
  output logic             andVals,
  output logic             notBVal,
  output logic             sub
);

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_LOADA, S_LOADB, S_EXEC, S_WRITE, S_WIMM, S_DONE, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_MOVI, C_MOV, C_ADD, C_CMP, C_AND, C_MVN, C_ILL
  } cls_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_instr;
  cls_t        w_cls_in;
  cls_t        w_cls;

  function automatic cls_t classify(input logic [4:0] opc_op);
    case (opc_op)
      5'b11010: classify = C_MOVI;
      5'b11000: classify = C_MOV;
      5'b10100: classify = C_ADD;
      5'b10101: classify = C_CMP;
      5'b10110: classify = C_AND;
      5'b10111: classify = C_MVN;
      default:  classify = C_ILL;
    endcase
  endfunction

  assign w_cls_in = classify(instr[15:11]);
  assign w_cls    = classify(r_instr[15:11]);
  assign sximm    = {{(WIDTH-IMM_W){r_instr[IMM_W-1]}}, r_instr[IMM_W-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start)
        r_instr <= instr;
    end
  end

  // Register-operand instructions dispatch straight from IDLE to their first
  // operand fetch; DECODE only sequences MOVI and illegal encodings.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (w_cls_in)
            C_ADD, C_CMP, C_AND: w_next = S_LOADA;
            C_MOV, C_MVN:        w_next = S_LOADB;
            default:             w_next = S_DECODE;
          endcase
        end
      end
      S_DECODE: begin
        case (w_cls)
          C_MOVI:              w_next = S_WIMM;
          C_ADD, C_CMP, C_AND: w_next = S_LOADA;
          C_MOV, C_MVN:        w_next = S_LOADB;
`ifdef ALU_OP_SEQ_TRAP_EN
          default:             w_next = S_TRAP;
`else
          default:             w_next = S_DONE;
`endif
        endcase
      end
      S_LOADA: w_next = S_LOADB;
      S_LOADB: w_next = S_EXEC;
      S_EXEC:  w_next = (w_cls == C_CMP) ? S_DONE : S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_WIMM:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready      = (r_state == S_IDLE);
    done       = 1'b0;
    err        = 1'b0;
    rd_addr    = 3'd0;
    wr_addr    = 3'd0;
    wr_en      = 1'b0;
    vsel       = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    addSubVals = 1'b0;
    andVals    = 1'b0;
    notBVal    = 1'b0;
    sub        = 1'b0;
    case (r_state)
      S_LOADA: begin
        rd_addr = r_instr[10:8];
        loada   = 1'b1;
      end
      S_LOADB: begin
        rd_addr = r_instr[2:0];
        loadb   = 1'b1;
      end
      S_EXEC: begin
        case (w_cls)
          C_ADD: begin addSubVals = 1'b1; loadc = 1'b1; end
          C_CMP: begin addSubVals = 1'b1; sub = 1'b1; loads = 1'b1; end
          C_AND: begin andVals = 1'b1; loadc = 1'b1; end
          C_MVN: begin notBVal = 1'b1; loadc = 1'b1; end
          C_MOV: begin addSubVals = 1'b1; asel = 1'b1; loadc = 1'b1; end
          default: ;
        endcase
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = r_instr[7:5];
      end
      S_WIMM: begin
        wr_en   = 1'b1;
        wr_addr = r_instr[10:8];
        vsel    = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        err  = (w_cls == C_ILL);
      end
      S_TRAP: err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed and random instructions against a decode-table model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic        ready, done, err, wr_en, vsel;
  logic [2:0]  rd_addr, wr_addr;
  logic [15:0] sximm;
  logic        loada, loadb, loadc, loads, asel, addSubVals, andVals, notBVal, sub;

  alu_op_sequencer #(.WIDTH(16), .IMM_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .ready(ready), .done(done), .err(err),
    .rd_addr(rd_addr), .wr_addr(wr_addr), .wr_en(wr_en), .vsel(vsel), .sximm(sximm),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
    .addSubVals(addSubVals), .andVals(andVals), .notBVal(notBVal), .sub(sub)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] ins;
    int          acc;
    int          lat;
    int          nwr;
    logic [2:0]  wa;
    logic        vs;
    logic [15:0] sx;
    int          na;
    logic [2:0]  ra;
    int          nb;
    logic [2:0]  rb;
    int          nc;
    int          ns;
    logic [4:0]  alu;
    logic        er;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Expected behaviour derived directly from the instruction table.
  function automatic exp_t model(input logic [15:0] ins, input int acc);
    exp_t e;
    int   v;
    e = '{ins: ins, acc: acc, lat: 0, nwr: 0, wa: 3'd0, vs: 1'b0, sx: 16'd0,
          na: 0, ra: 3'd0, nb: 0, rb: 3'd0, nc: 0, ns: 0, alu: 5'd0, er: 1'b0};
    case (ins[15:11])
      5'b11010: begin  // MOVI
        v = int'(ins[7:0]);
        if (v > 127) v -= 256;
        e.lat = 3; e.nwr = 1; e.wa = ins[10:8]; e.vs = 1'b1; e.sx = v[15:0];
      end
      5'b11000: begin  // MOV
        e.lat = 4; e.nb = 1; e.rb = ins[2:0]; e.nc = 1; e.alu = 5'b10001;
        e.nwr = 1; e.wa = ins[7:5];
      end
      5'b10100: begin  // ADD
        e.lat = 5; e.na = 1; e.ra = ins[10:8]; e.nb = 1; e.rb = ins[2:0];
        e.nc = 1; e.alu = 5'b10000; e.nwr = 1; e.wa = ins[7:5];
      end
      5'b10101: begin  // CMP
        e.lat = 4; e.na = 1; e.ra = ins[10:8]; e.nb = 1; e.rb = ins[2:0];
        e.ns = 1; e.alu = 5'b10010;
      end
      5'b10110: begin  // AND
        e.lat = 5; e.na = 1; e.ra = ins[10:8]; e.nb = 1; e.rb = ins[2:0];
        e.nc = 1; e.alu = 5'b01000; e.nwr = 1; e.wa = ins[7:5];
      end
      5'b10111: begin  // MVN
        e.lat = 4; e.nb = 1; e.rb = ins[2:0]; e.nc = 1; e.alu = 5'b00100;
        e.nwr = 1; e.wa = ins[7:5];
      end
      default: begin
        e.lat = 2; e.er = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Monitor: accumulates what the DUT did during one instruction, compares at done.
  int         o_nwr, o_na, o_nb, o_nc, o_ns;
  logic [2:0] o_wa, o_ra, o_rb;
  logic       o_vs, o_viol;
  logic [15:0] o_sx;
  logic [4:0] o_alu;

  task automatic clear_obs();
    o_nwr = 0; o_na = 0; o_nb = 0; o_nc = 0; o_ns = 0;
    o_wa = 3'd0; o_ra = 3'd0; o_rb = 3'd0; o_vs = 1'b0; o_viol = 1'b0;
    o_sx = 16'd0; o_alu = 5'd0;
  endtask

  initial clear_obs();

  always @(negedge clk) begin
    exp_t  e;
    string tag;
    if (reset) begin
      clear_obs();
    end else begin
      if (loada) begin o_na++; o_ra = rd_addr; end
      if (loadb) begin o_nb++; o_rb = rd_addr; end
      if (!(loada || loadb) && rd_addr != 3'd0) o_viol = 1'b1;
      if (loadc) o_nc++;
      if (loads) o_ns++;
      if (loadc || loads) o_alu = {addSubVals, andVals, notBVal, sub, asel};
      else if (addSubVals || andVals || notBVal || sub || asel) o_viol = 1'b1;
      if ((int'(addSubVals) + int'(andVals) + int'(notBVal)) > 1) o_viol = 1'b1;
      if (sub && !addSubVals) o_viol = 1'b1;
      if (wr_en) begin
        o_nwr++; o_wa = wr_addr; o_vs = vsel;
        if (vsel) o_sx = sximm;
      end else if (wr_addr != 3'd0 || vsel) o_viol = 1'b1;
      if (err && !done) o_viol = 1'b1;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          tag = $sformatf("ins=%h", e.ins);
          chk({tag, " latency"},    cyc - e.acc,     e.lat);
          chk({tag, " err"},        int'(err),       int'(e.er));
          chk({tag, " wr_count"},   o_nwr,           e.nwr);
          chk({tag, " wr_addr"},    int'(o_wa),      int'(e.wa));
          chk({tag, " vsel"},       int'(o_vs),      int'(e.vs));
          chk({tag, " sximm"},      int'(o_sx),      int'(e.sx));
          chk({tag, " loada_cnt"},  o_na,            e.na);
          chk({tag, " rd_addr_a"},  int'(o_ra),      int'(e.ra));
          chk({tag, " loadb_cnt"},  o_nb,            e.nb);
          chk({tag, " rd_addr_b"},  int'(o_rb),      int'(e.rb));
          chk({tag, " loadc_cnt"},  o_nc,            e.nc);
          chk({tag, " loads_cnt"},  o_ns,            e.ns);
          chk({tag, " alu_sel"},    int'(o_alu),     int'(e.alu));
          chk({tag, " qualify"},    int'(o_viol),    0);
        end
        clear_obs();
      end
    end
  end

  task automatic check_idle_outputs(input string nm);
    logic [34:0] v;
    v = {done, err, rd_addr, wr_addr, wr_en, vsel, sximm, loada, loadb, loadc, loads,
         asel, addSubVals, andVals, notBVal, sub};
    chk({nm, " outputs_zero"}, int'(v != 35'd0), 0);
    chk({nm, " ready"}, int'(ready), 1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [15:0] ins, input bit hold);
    int n = 0;
    instr = ins;
    start = 1'b1;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("issue_timeout", 1, 0);
      start = 1'b0;
      return;
    end
    exp_q.push_back(model(ins, cyc));
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", int'(ready), 1);
  endtask

  function automatic logic [15:0] rand_instr(input bit allow_illegal);
    logic [31:0] r;
    logic [4:0]  codes [6];
    int          k;
    codes = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};
    r = $urandom();
    k = int'($urandom_range(0, allow_illegal ? 6 : 5));
    if (k == 6) begin
      while (r[15:11] inside {5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111})
        r = $urandom();
      return r[15:0];
    end
    return {codes[k], r[10:0]};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit illegal_ok;
`ifdef ALU_OP_SEQ_TRAP_EN
    illegal_ok = 1'b0;
`else
    illegal_ok = 1'b1;
`endif
    reset = 1'b1;
    start = 1'b0;
    instr = 16'h0000;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    issue(16'hD205, 1'b0);
    issue(16'hD2FF, 1'b0);
    issue(16'hD37F, 1'b0);
    issue(16'hD480, 1'b0);
    issue(16'hA162, 1'b0);
    issue(16'hA902, 1'b0);
    issue(16'hB562, 1'b0);
    issue(16'hC0A3, 1'b0);

    // MVN with a competing start during EXEC that must be ignored.
    issue(16'hB887, 1'b0);
    @(negedge clk);
    start = 1'b1;
    instr = 16'hD5AA;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    if (illegal_ok) issue(16'h0000, 1'b0);

    for (int i = 0; i < 150; i++)
      issue(rand_instr(illegal_ok), bit'($urandom_range(0, 1)));
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Abort MVN in WRITE via reset.
    issue(16'hB887, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort wr_en_in_write", int'(wr_en), 1);
    #1 reset = 1'b1;
    #1 check_idle_outputs("abort");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    issue(16'hD7F0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);

`ifdef ALU_OP_SEQ_TRAP_EN
    instr = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      chk("trap err", int'(err), 1);
      chk("trap ready", int'(ready), 0);
      @(negedge clk);
    end
    reset = 1'b1;
    #1 check_idle_outputs("trap_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
